// File: rtl/core_pkg.sv
// core_pkg: shared encodings for the multicycle RV32I control path.
package core_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BEQ,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // States that own the memory port and wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: selects the immediate format from the opcode.
module imm_src_decoder
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  // Loads, I-type ALU and anything unknown use the I format.
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
//
// Memory handshake: mem_req is raised in FETCH/MEMRD/MEMWR and held until a
// cycle in which mem_ready=1; that cycle completes the access and the FSM
// leaves the state on the following edge. mem_ready while mem_req=0 is
// ignored. If MEM_TIMEOUT waiting cycles pass without mem_ready, the FSM
// enters TRAP; mem_ready on the limit cycle still completes the access.
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       trap,
  output state_t     state_dbg
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] cnt;
  logic          mem_wait;
  logic          timeout;

  assign mem_wait  = is_mem_state(state) && !mem_ready;
  assign timeout   = mem_wait && (cnt == TW'(MEM_TIMEOUT));
  assign state_dbg = state;

  imm_src_decoder u_imm (
    .opcode  (opcode),
    .imm_src (imm_src)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Wait counter: counts unanswered request cycles, zero everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt <= '0;
    else if (mem_wait && !timeout) cnt <= cnt + 1'b1;
    else                          cnt <= '0;
  end

  // Sticky trap flag, set together with the move into TRAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     trap <= 1'b0;
    else if (next_state == S_TRAP) trap <= 1'b1;
  end

  // Next-state sequencing.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    next_state = S_DECODE;
        else if (timeout) next_state = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    next_state = S_MEMWB;
        else if (timeout) next_state = S_TRAP;
      end
      S_MEMWB: next_state = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)    next_state = S_FETCH;
        else if (timeout) next_state = S_TRAP;
      end
      S_EXECR: next_state = S_ALUWB;
      S_EXECI: next_state = S_ALUWB;
      S_ALUWB: next_state = S_FETCH;
      S_JAL:   next_state = S_ALUWB;
      S_BEQ:   next_state = S_FETCH;
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_TRAP;
    endcase
  end

  // Moore output decode; everything is forced low while reset is held so the
  // memory request drops as soon as reset rises.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALU_FUNCT;
        end
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: reg_write = 1'b1;
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALU_SUB;
          pc_write  = zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scenario tests plus random instruction streams against
// a cycle-list model of the control sequence.
module tb_multicycle_ctrl;
  import core_pkg::*;

  localparam int T = 4;
  localparam int W = 17;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  state_t     state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .trap       (trap),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic         rdy_q[$];
  logic [6:0]   opc_q[$];
  logic         zero_q[$];
  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] mk(input logic rq, wr, adr, irw, pcw, rw,
                                      input logic [1:0] rs, a, b, op, im,
                                      input logic tr);
    return {rq, wr, adr, irw, pcw, rw, rs, a, b, op, im, tr};
  endfunction

  function automatic logic nz(input bit noise);
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic push(input logic [W-1:0] v, input logic r, input logic [6:0] o, input logic z);
    exp_q.push_back(v);
    rdy_q.push_back(r);
    opc_q.push_back(o);
    zero_q.push_back(z);
  endtask

  task automatic model_trap(input logic [6:0] o, input logic z, input int n, input bit noise);
    for (int i = 0; i < n; i++)
      push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm_of(o), 1'b1), nz(noise), o, z);
  endtask

  // Data access of n waiting cycles; more than T waits ends in the trap.
  task automatic model_mem(input logic wr, input logic [6:0] o, input logic z, input int n,
                           input bit noise, output bit tr);
    logic [1:0] im;
    im = imm_of(o);
    tr = 1'b0;
    for (int i = 0; i < n && i <= T; i++)
      push(mk(1, wr, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0), 1'b0, o, z);
    if (n > T) begin
      tr = 1'b1;
      model_trap(o, z, 6, noise);
    end else begin
      push(mk(1, wr, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0), 1'b1, o, z);
    end
  endtask

  // One whole instruction: fetch waits fw, data waits mw.
  task automatic add_instr(input logic [6:0] o, input logic z, input int fw, input int mw,
                           input bit noise);
    logic [1:0] im;
    bit tr;
    im = imm_of(o);
    for (int i = 0; i < fw && i <= T; i++)
      push(mk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, im, 1'b0), 1'b0, o, z);
    if (fw > T) begin
      model_trap(o, z, 6, noise);
      return;
    end
    push(mk(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, im, 1'b0), 1'b1, o, z);
    push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, 1'b0), nz(noise), o, z);
    if (o == OP_LOAD || o == OP_STORE) begin
      push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 1'b0), nz(noise), o, z);
      model_mem(o == OP_STORE, o, z, mw, noise, tr);
      if (!tr && o == OP_LOAD)
        push(mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, im, 1'b0), nz(noise), o, z);
    end else if (o == OP_R || o == OP_I) begin
      push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (o == OP_I) ? 2'b01 : 2'b00, 2'b10, im, 1'b0),
           nz(noise), o, z);
      push(mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0), nz(noise), o, z);
    end else if (o == OP_JAL) begin
      push(mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, im, 1'b0), nz(noise), o, z);
      push(mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0), nz(noise), o, z);
    end else if (o == OP_BRANCH) begin
      push(mk(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, 2'b01, im, 1'b0), nz(noise), o, z);
    end else begin
      model_trap(o, z, 8, noise);
    end
  endtask

  // ---------------- driver ----------------
  function automatic logic [W-1:0] observe();
    return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            result_src, alu_src_a, alu_src_b, alu_op, imm_src, trap};
  endfunction

  // Called just after a rising edge; drives one cycle of inputs, samples at
  // the falling edge and returns just after the next rising edge.
  task automatic play(input int ncyc);
    for (int i = 0; i < ncyc && rdy_q.size() > 0; i++) begin
      mem_ready = rdy_q.pop_front();
      opcode    = opc_q.pop_front();
      zero      = zero_q.pop_front();
      @(negedge clk);
      obs_q.push_back(observe());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (observe() !== '0 || state_dbg !== S_FETCH) begin
      bad++;
      $display("FAIL reset got=%b state=%0d want=%b state=%0d", observe(), state_dbg, {W{1'b0}}, S_FETCH);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    add_instr(OP_R, 1'b0, 0, 0, 1'b0);
    play(1000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL add cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_lw_sw();
    add_instr(OP_LOAD, 1'b0, 0, 3, 1'b0);
    add_instr(OP_STORE, 1'b1, 1, 2, 1'b1);
    add_instr(OP_I, 1'b0, 2, 0, 1'b1);
    play(1000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL lw_sw cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_beq_jal();
    add_instr(OP_BRANCH, 1'b1, 0, 0, 1'b0);
    add_instr(OP_BRANCH, 1'b0, 0, 0, 1'b1);
    add_instr(OP_JAL, 1'b0, 1, 0, 1'b1);
    play(1000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL beq_jal cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_limit();
    add_instr(OP_LOAD, 1'b0, T, T, 1'b1);
    add_instr(OP_STORE, 1'b0, T, T, 1'b0);
    play(1000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL limit cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_illegal();
    add_instr(7'b0000000, 1'b0, 0, 0, 1'b1);
    play(1000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL illegal cyc%0d got=%b want=%b", i, o, e); end
    end
    reset = 1'b1;
    #1;
    total++;
    if (trap !== 1'b0 || mem_req !== 1'b0 || state_dbg !== S_FETCH) begin
      bad++;
      $display("FAIL illegal_reset got trap=%b req=%b state=%0d want 0 0 %0d", trap, mem_req, state_dbg, S_FETCH);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    add_instr(OP_R, 1'b0, T + 1, 0, 1'b1);
    play(1000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL fetch_timeout cyc%0d got=%b want=%b", i, o, e); end
    end
    pulse_reset();
    add_instr(OP_LOAD, 1'b0, 0, T + 1, 1'b0);
    play(1000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL load_timeout cyc%0d got=%b want=%b", i, o, e); end
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    add_instr(OP_STORE, 1'b0, 0, 3, 1'b0);
    play(4);
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL mid_pre cyc%0d got=%b want=%b", i, o, e); end
    end
    total++;
    if (mem_req !== exp_q[0][W-1] || mem_write !== exp_q[0][W-2]) begin
      bad++;
      $display("FAIL mid_hold got req=%b wr=%b want req=%b wr=%b", mem_req, mem_write, exp_q[0][W-1], exp_q[0][W-2]);
    end
    exp_q.delete(); rdy_q.delete(); opc_q.delete(); zero_q.delete();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_write !== 1'b0 || trap !== 1'b0) begin
      bad++;
      $display("FAIL mid_async got req=%b wr=%b trap=%b want 0 0 0", mem_req, mem_write, trap);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    add_instr(OP_I, 1'b0, 1, 0, 1'b0);
    play(1000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL mid_after cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[6];
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL};
    for (int n = 0; n < 40; n++)
      add_instr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, T)), int'($urandom_range(0, T)), 1'b1);
    play(5000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL random cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_lw_sw();
    test_beq_jal();
    test_limit();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
